// File: rtl/shift_ex_operand_stage_if.sv
// ID/EX shift operand stage bus: decode slot, hazard controls,
// forwarding sources and EX-side shifter controls.
interface shift_ex_operand_stage_if #(
  parameter int N     = 32,
  parameter int CNT_W = 16
);
  logic             stall;
  logic             flush;
  logic             id_valid;
  logic             id_is_shift;
  logic             id_use_imm;
  logic [2:0]       id_funct3;
  logic             id_funct7b5;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic [4:0]       id_rd;
  logic [N-1:0]     id_rs1_data;
  logic [N-1:0]     id_rs2_data;
  logic [N-1:0]     id_imm;
  logic             exmem_regwrite;
  logic             memwb_regwrite;
  logic [4:0]       exmem_rd;
  logic [4:0]       memwb_rd;
  logic [N-1:0]     exmem_result;
  logic [N-1:0]     memwb_result;
  logic             ex_valid;
  logic             ex_illegal;
  logic [4:0]       ex_rd;
  logic [N-1:0]     sh_a;
  logic [4:0]       sh_shamt;
  logic [1:0]       sh_type;
  logic [CNT_W-1:0] shift_cnt;

  modport master (
    output stall, flush, id_valid, id_is_shift,
    output id_use_imm, id_funct3, id_funct7b5,
    output id_rs1, id_rs2, id_rd,
    output id_rs1_data, id_rs2_data, id_imm,
    output exmem_regwrite, memwb_regwrite,
    output exmem_rd, memwb_rd,
    output exmem_result, memwb_result,
    input  ex_valid, ex_illegal, ex_rd,
    input  sh_a, sh_shamt, sh_type, shift_cnt
  );

  modport slave (
    input  stall, flush, id_valid, id_is_shift,
    input  id_use_imm, id_funct3, id_funct7b5,
    input  id_rs1, id_rs2, id_rd,
    input  id_rs1_data, id_rs2_data, id_imm,
    input  exmem_regwrite, memwb_regwrite,
    input  exmem_rd, memwb_rd,
    input  exmem_result, memwb_result,
    output ex_valid, ex_illegal, ex_rd,
    output sh_a, sh_shamt, sh_type, shift_cnt
  );
endinterface

// File: rtl/shift_ex_operand_stage.sv
// ID/EX register for shift ops with EX-side operand forwarding
// and a saturating issued-shift counter.
module shift_ex_operand_stage #(
  parameter int N     = 32,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  shift_ex_operand_stage_if.slave bus
);

  typedef struct packed {
    logic         valid;
    logic         illegal;
    logic [1:0]   typ;
    logic         use_imm;
    logic [4:0]   rs1;
    logic [4:0]   rs2;
    logic [4:0]   rd;
    logic [N-1:0] rs1_data;
    logic [N-1:0] rs2_data;
    logic [4:0]   imm;
  } id_ex_t;

  id_ex_t           id_ex_q, id_ex_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       typ_dec;
  logic             ill_dec;
  logic [N-1:0]     rs1_fwd, rs2_fwd;
  logic             unused_bits;

  always_comb begin
    typ_dec = 2'b00;
    ill_dec = 1'b1;
    unique case (1'b1)
      (bus.id_funct3 == 3'b001 && !bus.id_funct7b5): begin
        typ_dec = 2'b01;
        ill_dec = 1'b0;
      end
      (bus.id_funct3 == 3'b101 && !bus.id_funct7b5): begin
        typ_dec = 2'b00;
        ill_dec = 1'b0;
      end
      (bus.id_funct3 == 3'b101 && bus.id_funct7b5): begin
        typ_dec = 2'b10;
        ill_dec = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    id_ex_d.valid    = bus.id_valid & bus.id_is_shift;
    id_ex_d.illegal  = ill_dec;
    id_ex_d.typ      = typ_dec;
    id_ex_d.use_imm  = bus.id_use_imm;
    id_ex_d.rs1      = bus.id_rs1;
    id_ex_d.rs2      = bus.id_rs2;
    id_ex_d.rd       = bus.id_rd;
    id_ex_d.rs1_data = bus.id_rs1_data;
    id_ex_d.rs2_data = bus.id_rs2_data;
    id_ex_d.imm      = bus.id_imm[4:0];
  end

  always_comb begin
    cnt_d = cnt_q;
    if (id_ex_d.valid && cnt_q != {CNT_W{1'b1}})
      cnt_d = cnt_q + 1'b1;
  end

  // flush only kills the slot flags; datapath fields stay put
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ex_q <= '0;
      cnt_q   <= '0;
    end else if (bus.flush) begin
      id_ex_q.valid   <= 1'b0;
      id_ex_q.illegal <= 1'b0;
    end else if (!bus.stall) begin
      id_ex_q <= id_ex_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    rs1_fwd = id_ex_q.rs1_data;
    if (bus.exmem_regwrite && bus.exmem_rd != 5'd0 &&
        bus.exmem_rd == id_ex_q.rs1)
      rs1_fwd = bus.exmem_result;
    else if (bus.memwb_regwrite && bus.memwb_rd != 5'd0 &&
             bus.memwb_rd == id_ex_q.rs1)
      rs1_fwd = bus.memwb_result;
  end

  always_comb begin
    rs2_fwd = id_ex_q.rs2_data;
    if (bus.exmem_regwrite && bus.exmem_rd != 5'd0 &&
        bus.exmem_rd == id_ex_q.rs2)
      rs2_fwd = bus.exmem_result;
    else if (bus.memwb_regwrite && bus.memwb_rd != 5'd0 &&
             bus.memwb_rd == id_ex_q.rs2)
      rs2_fwd = bus.memwb_result;
  end

  assign unused_bits = ^{rs2_fwd[N-1:5], bus.id_imm[N-1:5]};

  assign bus.ex_valid   = id_ex_q.valid;
  assign bus.ex_illegal = id_ex_q.illegal;
  assign bus.ex_rd      = id_ex_q.rd;
  assign bus.sh_a       = rs1_fwd;
  assign bus.sh_shamt   = id_ex_q.use_imm ? id_ex_q.imm
                                          : rs2_fwd[4:0];
  assign bus.sh_type    = id_ex_q.typ;
  assign bus.shift_cnt  = cnt_q;

endmodule

// File: tb/tb_shift_ex_operand_stage.sv
// Directed bench for shift_ex_operand_stage; a queue-based
// scoreboard checks a 16-bit and a 2-bit counter instance.
module tb_shift_ex_operand_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  shift_ex_operand_stage_if #(.N(32), .CNT_W(16)) b1 ();
  shift_ex_operand_stage_if #(.N(32), .CNT_W(2))  b2 ();

  shift_ex_operand_stage #(.N(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(b1)
  );
  shift_ex_operand_stage #(.N(32), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(b2)
  );

  assign b2.stall          = b1.stall;
  assign b2.flush          = b1.flush;
  assign b2.id_valid       = b1.id_valid;
  assign b2.id_is_shift    = b1.id_is_shift;
  assign b2.id_use_imm     = b1.id_use_imm;
  assign b2.id_funct3      = b1.id_funct3;
  assign b2.id_funct7b5    = b1.id_funct7b5;
  assign b2.id_rs1         = b1.id_rs1;
  assign b2.id_rs2         = b1.id_rs2;
  assign b2.id_rd          = b1.id_rd;
  assign b2.id_rs1_data    = b1.id_rs1_data;
  assign b2.id_rs2_data    = b1.id_rs2_data;
  assign b2.id_imm         = b1.id_imm;
  assign b2.exmem_regwrite = b1.exmem_regwrite;
  assign b2.memwb_regwrite = b1.memwb_regwrite;
  assign b2.exmem_rd       = b1.exmem_rd;
  assign b2.memwb_rd       = b1.memwb_rd;
  assign b2.exmem_result   = b1.exmem_result;
  assign b2.memwb_result   = b1.memwb_result;

  typedef struct {
    logic        v;
    logic        ill;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [4:0]  sh;
    logic [1:0]  ty;
    logic [15:0] c;
    logic [1:0]  c2;
  } exp_t;

  exp_t q[$];
  int ncmp = 0;
  int nerr = 0;

  task automatic cmp(string nm, logic [31:0] act,
                     logic [31:0] req);
    ncmp++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      cmp("ex_valid",   32'(b1.ex_valid),   32'(e.v));
      cmp("ex_illegal", 32'(b1.ex_illegal), 32'(e.ill));
      cmp("ex_rd",      32'(b1.ex_rd),      32'(e.rd));
      cmp("sh_a",       b1.sh_a,            e.a);
      cmp("sh_shamt",   32'(b1.sh_shamt),   32'(e.sh));
      cmp("sh_type",    32'(b1.sh_type),    32'(e.ty));
      cmp("shift_cnt",  32'(b1.shift_cnt),  32'(e.c));
      cmp("shift_cnt2", 32'(b2.shift_cnt),  32'(e.c2));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(logic v, logic ill, logic [4:0] rd,
                            logic [31:0] a, logic [4:0] sh,
                            logic [1:0] ty, logic [15:0] c);
    exp_t e;
    e.v = v; e.ill = ill; e.rd = rd; e.a = a;
    e.sh = sh; e.ty = ty; e.c = c;
    e.c2 = (c > 16'd3) ? 2'd3 : c[1:0];
    #1 q.push_back(e);
  endtask

  task automatic setid(logic v, logic s, logic ui,
                       logic [2:0] f3, logic f7,
                       logic [4:0] r1, logic [4:0] r2,
                       logic [4:0] rd, logic [31:0] d1,
                       logic [31:0] d2, logic [31:0] imm);
    b1.id_valid = v; b1.id_is_shift = s;
    b1.id_use_imm = ui; b1.id_funct3 = f3;
    b1.id_funct7b5 = f7; b1.id_rs1 = r1;
    b1.id_rs2 = r2; b1.id_rd = rd;
    b1.id_rs1_data = d1; b1.id_rs2_data = d2;
    b1.id_imm = imm;
  endtask

  task automatic setfwd(logic ew, logic [4:0] erd,
                        logic [31:0] er, logic mw,
                        logic [4:0] mrd, logic [31:0] mr);
    b1.exmem_regwrite = ew; b1.exmem_rd = erd;
    b1.exmem_result = er; b1.memwb_regwrite = mw;
    b1.memwb_rd = mrd; b1.memwb_result = mr;
  endtask

  initial begin
    b1.stall = 0; b1.flush = 0;
    setid(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    setfwd(0, 0, 0, 0, 0, 0);
    tick();
    expect_out(0, 0, 0, 0, 0, 0, 0);
    tick();
    rst_n = 1;
    // SRAI x3, x1, 4
    setid(1, 1, 1, 3'b101, 1, 1, 0, 3, 32'h8000_00F0, 0, 4);
    tick();
    // next in ID: SLL x4, x5, x6
    setid(1, 1, 0, 3'b001, 0, 5, 6, 4, 32'h1, 32'h2, 0);
    expect_out(1, 0, 3, 32'h8000_00F0, 4, 2'b10, 1);
    tick();
    // next in ID: SRL x9, x8, x7
    setid(1, 1, 0, 3'b101, 0, 8, 7, 9, 32'h55, 32'h10, 0);
    setfwd(1, 5, 32'h1234, 1, 5, 32'hDEAD);
    b1.stall = 1;
    expect_out(1, 0, 4, 32'h1234, 2, 2'b01, 2);
    tick();
    b1.stall = 0;
    setfwd(0, 5, 32'h1234, 1, 5, 32'hDEAD);
    expect_out(1, 0, 4, 32'hDEAD, 2, 2'b01, 2);
    tick();
    // next in ID: SRL x10, x2, x0
    setid(1, 1, 0, 3'b101, 0, 2, 0, 10, 32'h77, 32'hB, 0);
    setfwd(0, 0, 0, 1, 7, 32'hFFFF_FFE3);
    expect_out(1, 0, 9, 32'h55, 3, 2'b00, 3);
    tick();
    // next in ID: SLLI x11, x3, 5
    setid(1, 1, 1, 3'b001, 0, 3, 0, 11, 32'hF00D, 0, 32'h25);
    setfwd(1, 0, 32'h1E, 1, 0, 32'h1F);
    expect_out(1, 0, 10, 32'h77, 11, 2'b00, 4);
    tick();
    setfwd(0, 0, 0, 0, 0, 0);
    b1.stall = 1;
    setid(1, 1, 1, 3'b101, 1, 4, 0, 12, 32'hAAAA, 0, 7);
    expect_out(1, 0, 11, 32'hF00D, 5, 2'b01, 5);
    for (int i = 0; i < 3; i++) begin
      tick();
      setid(1, 1, 1, 3'b101, 1, 4, 0, 5'(12 + i),
            32'hAAAA + i, 0, 7 + i);
      if (i == 2) b1.flush = 1;
      expect_out(1, 0, 11, 32'hF00D, 5, 2'b01, 5);
    end
    tick();
    b1.stall = 0; b1.flush = 0;
    // illegal: funct3=001 with f7b5=1
    setid(1, 1, 1, 3'b001, 1, 4, 0, 13, 32'h1111, 0, 2);
    expect_out(0, 0, 11, 32'hF00D, 5, 2'b01, 5);
    tick();
    b1.flush = 1;
    expect_out(1, 1, 13, 32'h1111, 2, 2'b00, 6);
    tick();
    b1.flush = 0;
    setid(1, 1, 1, 3'b010, 0, 4, 0, 14, 32'h2222, 0, 9);
    expect_out(0, 0, 13, 32'h1111, 2, 2'b00, 6);
    tick();
    setid(1, 0, 1, 3'b101, 0, 4, 0, 15, 32'h3333, 0, 1);
    expect_out(1, 1, 14, 32'h2222, 9, 2'b00, 7);
    tick();
    setid(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_out(0, 0, 15, 32'h3333, 1, 2'b00, 7);
    tick();
    rst_n = 0;
    expect_out(0, 0, 0, 0, 0, 2'b00, 0);
    @(negedge clk);
    #1 rst_n = 1;
    for (int i = 1; i <= 5; i++) begin
      setid(1, 1, 1, 3'b101, 0, 1, 0, 5'(i),
            32'(i), 0, 32'(i));
      tick();
      expect_out(1, 0, 5'(i), 32'(i), 5'(i), 2'b00, 16'(i));
    end
    tick();
    begin
      int budget;
      budget = 0;
      while (q.size() > 0 && budget < 20) begin
        @(posedge clk);
        budget++;
      end
      if (q.size() > 0) begin
        nerr++;
        $display("FAIL drain: got %0d pending want 0", q.size());
      end
    end
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
